mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage sitting between the execute stage and write-back. Consumes the ALU result (address or data), rs2 store data and trap state; loads and stores go over a single-master Wishbone-classic data bus. Loads are sign- or zero-extended, and misaligned or faulting accesses become precise traps. The pipeline is stalled while a bus access is pending.

## Interface
- TIMEOUT_CYCLES, 255: bus cycles without ack/err before access fault; 0 disables the watchdog.
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- valid_i  in  1  an instruction is presented from execute
- mem_rd_i / mem_wr_i  in  1 each  load / store (never both)
- mem_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_unsigned_i  in  1  zero-extend load (LBU/LHU)
- alu_out_i  in  32  effective address, or result for non-memory ops
- rs2_data_i  in  32  store data
- rd_i  in  5; reg_we_i  in  1; PC_i  in  32
- is_trap_i  in  1; trap_code_i  in  4  upstream trap
- stall_o  out  1  upstream must hold all inputs stable
- dbus_adr_o 32, dbus_dat_o 32, dbus_sel_o 4, dbus_we_o 1, dbus_cyc_o 1, dbus_stb_o 1  out
- dbus_dat_i 32, dbus_ack_i 1, dbus_err_i 1  in
- valid_o 1, rd_o 5, reg_we_o 1, result_o 32, PC_o 32, is_trap_o 1, trap_code_o 4  out, registered to write-back

## Operation
- FSM states IDLE, BUS.
- IDLE, valid_i=0: register a bubble (valid_o=0).
- IDLE, valid_i and is_trap_i: forward trap unchanged, no bus access.
- IDLE, valid_i, no memory op: result_o=alu_out_i, others forwarded.
- IDLE, memory op, misaligned (half with addr[0]=1; word with addr[1:0]!=0): no bus access. Register is_trap_o=1, trap_code_o=4 (load) or 6 (store), result_o=alu_out_i (faulting address), reg_we_o=0.
- IDLE, aligned memory op: register the bus outputs, go to BUS, clear watchdog.
  - dbus_adr_o={addr[31:2],2'b00}.
  - dbus_sel_o: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - dbus_dat_o: byte {4{rs2[7:0]}}, half {2{rs2[15:0]}}, word rs2.
  - dbus_we_o=mem_wr_i.
- BUS: cyc/stb held high, all bus outputs stable until ack or err.
  - ack: load shifts dbus_dat_i right by 8*addr[1:0], then sign/zero-extends byte/half into result_o. Store sets result_o=0 and reg_we_o=0.
  - err or watchdog expiry: trap code 5 (load) or 7 (store), result_o=address, reg_we_o=0.
  - In all three cases: drop cyc/stb, valid_o=1, return to IDLE.
- ack and err in the same cycle: err wins.
- Watchdog: counter increments each BUS cycle. Expiry when count reaches TIMEOUT_CYCLES with no ack/err.
- reg_we_o=reg_we_i & ~is_trap_o & ~store.
- stall_o=(IDLE & valid_i & ~is_trap_i & aligned memory op) | (BUS & ~dbus_ack_i & ~dbus_err_i & ~timeout).

## Timing
- Reset (async, immediate): state IDLE; dbus_cyc_o=dbus_stb_o=dbus_we_o=0, dbus_sel_o=0, dbus_adr_o=dbus_dat_o=0; valid_o=0, reg_we_o=0, is_trap_o=0, trap_code_o=0, result_o=0, rd_o=0, PC_o=0; watchdog 0.
- Reset mid-access abandons the cycle: cyc/stb fall asynchronously, nothing is retired.
- Non-memory, trapped or misaligned instruction: 1-cycle latency, no stall.
- Memory access issued in cycle 0: stall_o=1 in cycle 0, bus active from cycle 1.
  - Ack in cycle k≥1: stall_o=0 in cycle k, valid_o=1 in cycle k+1.
  - Zero-wait slave: 2-cycle latency, 1 stall cycle.
- During stall valid_o=0 (bubble into write-back); an instruction is retired exactly once.
- Back-to-back accesses: a new access may start in the IDLE cycle right after ack. cyc deasserts for at least one cycle between accesses.

## Test plan
- ADD result 0x0000_1234, rd=5, reg_we=1 -> next cycle valid_o=1, result_o=0x1234, rd_o=5, no bus activity.
- LB addr 0x103, dbus_dat_i=0x80xx_xxxx, ack after 2 waits -> sel=1000, adr=0x100, stall_o 3 cycles, result_o=0xFFFF_FF80. Same access with LBU -> 0x0000_0080.
- SH addr 0x202, rs2=0xAAAA_BEEF -> sel=1100, dat_o=0xBEEF_BEEF, we=1, reg_we_o=0, result_o=0.
- LW addr 0x301 -> no cyc, is_trap_o=1, trap_code_o=4, result_o=0x301. SW addr 0x302 -> trap_code_o=6.
- SW with err (plus simultaneous ack) -> trap_code_o=7. LW with slave silent, TIMEOUT_CYCLES=4 -> trap_code_o=5 after 4 BUS cycles, stall released.
- rst_n_i low during BUS -> cyc/stb low the same cycle, valid_o=0. After release, a fresh LW completes normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// Wishbone-classic data-bus bundle between the memory stage (master) and the data slave.
// Latency: none, wiring only.
// Backpressure: the slave stretches a cycle by withholding ack/err; the master holds cyc/stb and all outputs until then.
interface mem_stage_if;
    logic [31:0] dbus_adr_o;
    logic [31:0] dbus_dat_o;
    logic [3:0]  dbus_sel_o;
    logic        dbus_we_o;
    logic        dbus_cyc_o;
    logic        dbus_stb_o;
    logic [31:0] dbus_dat_i;
    logic        dbus_ack_i;
    logic        dbus_err_i;

    modport master (
        output dbus_adr_o, dbus_dat_o, dbus_sel_o, dbus_we_o, dbus_cyc_o, dbus_stb_o,
        input  dbus_dat_i, dbus_ack_i, dbus_err_i
    );

    modport slave (
        input  dbus_adr_o, dbus_dat_o, dbus_sel_o, dbus_we_o, dbus_cyc_o, dbus_stb_o,
        output dbus_dat_i, dbus_ack_i, dbus_err_i
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues Wishbone loads/stores, extends load data, turns misalignment and bus faults into precise traps.
// Latency: 1 cycle for non-memory, trapped or misaligned ops; 1 + bus cycles for accesses (2 with a zero-wait slave).
// Backpressure: stall_o holds upstream while an access is pending; write-back receives bubbles until the access retires.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [31:0] alu_out_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  rd_i,
    input  logic        reg_we_i,
    input  logic [31:0] PC_i,
    input  logic        is_trap_i,
    input  logic [3:0]  trap_code_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [4:0]  rd_o,
    output logic        reg_we_o,
    output logic [31:0] result_o,
    output logic [31:0] PC_o,
    output logic        is_trap_o,
    output logic [3:0]  trap_code_o,
    mem_stage_if.master dbus
);
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [0:0] {S_IDLE, S_BUS} state_t;

    state_t         r_state, w_state_nxt;
    logic [WDW-1:0] r_wdog;
    logic           r_valid, r_reg_we, r_trap, r_cyc, r_we;
    logic [3:0]     r_code, r_sel;
    logic [4:0]     r_rd;
    logic [31:0]    r_result, r_pc, r_adr, r_dat;

    logic           w_valid_nxt, w_reg_we_nxt, w_trap_nxt, w_cyc_nxt, w_we_nxt, w_stall;
    logic [3:0]     w_code_nxt, w_sel_nxt, w_st_sel;
    logic [4:0]     w_rd_nxt;
    logic [31:0]    w_result_nxt, w_pc_nxt, w_adr_nxt, w_dat_nxt, w_st_dat, w_shift, w_ld_data;
    logic           w_mem_op, w_misal, w_issue, w_timeout, w_done, w_fault;

    // Decode the presented instruction: memory op, alignment, and whether it starts a bus access
    assign w_mem_op  = mem_rd_i | mem_wr_i;
    assign w_misal   = ((mem_size_i == 2'b01) && alu_out_i[0]) ||
                       (mem_size_i[1] && (alu_out_i[1:0] != 2'b00));
    assign w_issue   = (r_state == S_IDLE) && valid_i && !is_trap_i && w_mem_op && !w_misal;
    // Watchdog only fires when the slave gave no response in this cycle, so a late ack still wins
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (32'(r_wdog) + 32'd1 == TIMEOUT_CYCLES) &&
                       !dbus.dbus_ack_i && !dbus.dbus_err_i;
    assign w_done    = (r_state == S_BUS) && (dbus.dbus_ack_i || dbus.dbus_err_i || w_timeout);
    assign w_fault   = dbus.dbus_err_i || w_timeout;

    // Store lane select and replicated write data
    always_comb begin
        w_st_sel = 4'b1111;
        w_st_dat = rs2_data_i;
        case (mem_size_i)
            2'b00: begin
                w_st_sel = 4'b0001 << alu_out_i[1:0];
                w_st_dat = {4{rs2_data_i[7:0]}};
            end
            2'b01: begin
                w_st_sel = 4'b0011 << alu_out_i[1:0];
                w_st_dat = {2{rs2_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Align returned load data to bit 0, then sign- or zero-extend to 32 bits
    always_comb begin
        w_shift   = dbus.dbus_dat_i >> {alu_out_i[1:0], 3'b000};
        w_ld_data = w_shift;
        case (mem_size_i)
            2'b00:   w_ld_data = mem_unsigned_i ? {24'd0, w_shift[7:0]}
                                                : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_ld_data = mem_unsigned_i ? {16'd0, w_shift[15:0]}
                                                : {{16{w_shift[15]}}, w_shift[15:0]};
            default: ;
        endcase
    end

    // FSM state register; reset abandons any in-flight access
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next state: enter BUS on an aligned access, leave on ack, err or watchdog expiry
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_issue) w_state_nxt = S_BUS;
            S_BUS:   if (w_done)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: stall plus next values of the write-back and bus registers
    always_comb begin
        w_stall      = 1'b0;
        w_valid_nxt  = 1'b0;
        w_reg_we_nxt = 1'b0;
        w_trap_nxt   = 1'b0;
        w_code_nxt   = r_code;
        w_result_nxt = r_result;
        w_rd_nxt     = r_rd;
        w_pc_nxt     = r_pc;
        w_cyc_nxt    = r_cyc;
        w_adr_nxt    = r_adr;
        w_dat_nxt    = r_dat;
        w_sel_nxt    = r_sel;
        w_we_nxt     = r_we;
        unique case (r_state)
            S_IDLE: begin
                if (valid_i) begin
                    w_valid_nxt  = !w_issue;
                    w_rd_nxt     = rd_i;
                    w_pc_nxt     = PC_i;
                    w_result_nxt = alu_out_i;
                    if (is_trap_i) begin
                        w_trap_nxt = 1'b1;
                        w_code_nxt = trap_code_i;
                    end else if (w_mem_op && w_misal) begin
                        w_trap_nxt = 1'b1;
                        w_code_nxt = mem_wr_i ? 4'd6 : 4'd4;
                    end else if (w_mem_op) begin
                        w_stall   = 1'b1;
                        w_cyc_nxt = 1'b1;
                        w_adr_nxt = {alu_out_i[31:2], 2'b00};
                        w_dat_nxt = w_st_dat;
                        w_sel_nxt = w_st_sel;
                        w_we_nxt  = mem_wr_i;
                    end else begin
                        w_code_nxt   = trap_code_i;
                        w_reg_we_nxt = reg_we_i;
                    end
                end
            end
            S_BUS: begin
                if (w_done) begin
                    w_valid_nxt = 1'b1;
                    w_rd_nxt    = rd_i;
                    w_pc_nxt    = PC_i;
                    w_cyc_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    if (w_fault) begin
                        w_trap_nxt   = 1'b1;
                        w_code_nxt   = mem_wr_i ? 4'd7 : 4'd5;
                        w_result_nxt = alu_out_i;
                    end else if (mem_wr_i) begin
                        w_result_nxt = 32'd0;
                    end else begin
                        w_result_nxt = w_ld_data;
                        w_reg_we_nxt = reg_we_i;
                    end
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Write-back and bus output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid  <= 1'b0;
            r_reg_we <= 1'b0;
            r_trap   <= 1'b0;
            r_code   <= 4'd0;
            r_result <= 32'd0;
            r_rd     <= 5'd0;
            r_pc     <= 32'd0;
            r_cyc    <= 1'b0;
            r_adr    <= 32'd0;
            r_dat    <= 32'd0;
            r_sel    <= 4'd0;
            r_we     <= 1'b0;
        end else begin
            r_valid  <= w_valid_nxt;
            r_reg_we <= w_reg_we_nxt;
            r_trap   <= w_trap_nxt;
            r_code   <= w_code_nxt;
            r_result <= w_result_nxt;
            r_rd     <= w_rd_nxt;
            r_pc     <= w_pc_nxt;
            r_cyc    <= w_cyc_nxt;
            r_adr    <= w_adr_nxt;
            r_dat    <= w_dat_nxt;
            r_sel    <= w_sel_nxt;
            r_we     <= w_we_nxt;
        end
    end

    // Watchdog counts BUS cycles and is cleared whenever the stage is idle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                r_wdog <= '0;
        else if (r_state == S_IDLE)  r_wdog <= '0;
        else                         r_wdog <= r_wdog + WDW'(1);
    end

    assign stall_o         = w_stall;
    assign valid_o         = r_valid;
    assign rd_o            = r_rd;
    assign reg_we_o        = r_reg_we;
    assign result_o        = r_result;
    assign PC_o            = r_pc;
    assign is_trap_o       = r_trap;
    assign trap_code_o     = r_code;
    assign dbus.dbus_adr_o = r_adr;
    assign dbus.dbus_dat_o = r_dat;
    assign dbus.dbus_sel_o = r_sel;
    assign dbus.dbus_we_o  = r_we;
    assign dbus.dbus_cyc_o = r_cyc;
    assign dbus.dbus_stb_o = r_cyc;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases then random ops against a behavioural model and a reactive bus slave.
// Latency: checks stall count, bus cycle count and retirement cycle of every op.
// Backpressure: slave inserts 0..3 wait states, errors, or stays silent to trip the watchdog.
module tb_mem_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, mem_rd_i, mem_wr_i, mem_unsigned_i, reg_we_i, is_trap_i;
    logic [1:0]  mem_size_i;
    logic [31:0] alu_out_i, rs2_data_i, PC_i;
    logic [4:0]  rd_i;
    logic [3:0]  trap_code_i;
    logic        stall_o, valid_o, reg_we_o, is_trap_o;
    logic [4:0]  rd_o;
    logic [31:0] result_o, PC_o;
    logic [3:0]  trap_code_o;
    int          total = 0;
    int          bad   = 0;

    mem_stage_if dbus();

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .valid_i(valid_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
        .alu_out_i(alu_out_i), .rs2_data_i(rs2_data_i), .rd_i(rd_i),
        .reg_we_i(reg_we_i), .PC_i(PC_i), .is_trap_i(is_trap_i), .trap_code_i(trap_code_i),
        .stall_o(stall_o), .valid_o(valid_o), .rd_o(rd_o), .reg_we_o(reg_we_o),
        .result_o(result_o), .PC_o(PC_o), .is_trap_o(is_trap_o), .trap_code_o(trap_code_o),
        .dbus(dbus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time bound exceeded");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // resp: 0 ack, 1 err, 2 err+ack together, 3 silent slave
    task automatic run_op(input string nm, input bit trp, input bit rd, input bit wr,
                          input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [4:0] rdx, input bit rwe,
                          input int waits, input int resp, input logic [31:0] rdata, input bit gap);
        int n, exp_bc, bc, stalls;
        bit memop, misal, bus, done, e_trap, e_we;
        logic [31:0] e_res, e_adr, e_dat, pc;
        logic [3:0] e_code, e_sel, tc;
        longint unsigned v, m;

        pc = $urandom;
        tc = 4'($urandom);
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        memop = rd | wr;
        misal = (addr % n) != 0;
        bus = !trp && memop && !misal;
        exp_bc = bus ? ((resp == 3) ? TO : waits + 1) : 0;
        e_adr = addr - (addr % 4);
        e_sel = 4'(((1 << n) - 1) << (addr % 4));
        e_dat = (n == 1) ? (rs2 & 32'hFF) * 32'h01010101 :
                (n == 2) ? (rs2 & 32'hFFFF) * 32'h00010001 : rs2;
        e_trap = 1'b0; e_we = 1'b0; e_code = 4'd0; e_res = addr;
        if (trp) begin
            e_trap = 1'b1; e_code = tc;
        end else if (!memop) begin
            e_we = rwe;
        end else if (misal) begin
            e_trap = 1'b1; e_code = wr ? 4'd6 : 4'd4;
        end else if (resp != 0) begin
            e_trap = 1'b1; e_code = wr ? 4'd7 : 4'd5;
        end else if (wr) begin
            e_res = 32'd0;
        end else begin
            m = 64'd1 << (8 * n);
            v = (64'(rdata) >> (8 * (addr % 4))) % m;
            if (!uns && v >= m / 2) v = v + (64'd1 << 32) - m;
            e_res = 32'(v);
            e_we = rwe;
        end

        valid_i = 1'b1; is_trap_i = trp; trap_code_i = tc;
        mem_rd_i = rd; mem_wr_i = wr; mem_size_i = sz; mem_unsigned_i = uns;
        alu_out_i = addr; rs2_data_i = rs2; rd_i = rdx; reg_we_i = rwe; PC_i = pc;
        dbus.dbus_dat_i = rdata; dbus.dbus_ack_i = 1'b0; dbus.dbus_err_i = 1'b0;

        bc = 0; stalls = 0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (dbus.dbus_cyc_o) begin
                bc++;
                if (bc == 1) begin
                    chk({nm, ":adr"}, dbus.dbus_adr_o, e_adr);
                    chk({nm, ":sel"}, 32'(dbus.dbus_sel_o), 32'(e_sel));
                    chk({nm, ":we"}, 32'(dbus.dbus_we_o), 32'(wr));
                    chk({nm, ":stb"}, 32'(dbus.dbus_stb_o), 32'd1);
                    if (wr) chk({nm, ":dat_o"}, dbus.dbus_dat_o, e_dat);
                end
                if (resp != 3 && bc == waits + 1) begin
                    dbus.dbus_ack_i = (resp == 0 || resp == 2);
                    dbus.dbus_err_i = (resp == 1 || resp == 2);
                end
            end
            @(negedge clk);
            if (c > 0) chk({nm, ":bubble"}, 32'(valid_o), 32'd0);
            if (stall_o) stalls++;
            else done = 1'b1;
            @(posedge clk); #1;
            dbus.dbus_ack_i = 1'b0; dbus.dbus_err_i = 1'b0;
        end
        valid_i = 1'b0;
        if (!done) chk({nm, ":stall_never_released"}, 32'(stall_o), 32'd0);
        chk({nm, ":stalls"}, 32'(stalls), 32'(exp_bc));
        chk({nm, ":bus_cycles"}, 32'(bc), 32'(exp_bc));
        chk({nm, ":valid"}, 32'(valid_o), 32'd1);
        chk({nm, ":rd"}, 32'(rd_o), 32'(rdx));
        chk({nm, ":pc"}, PC_o, pc);
        chk({nm, ":trap"}, 32'(is_trap_o), 32'(e_trap));
        if (e_trap) chk({nm, ":code"}, 32'(trap_code_o), 32'(e_code));
        chk({nm, ":reg_we"}, 32'(reg_we_o), 32'(e_we));
        chk({nm, ":result"}, result_o, e_res);
        chk({nm, ":cyc_after"}, 32'(dbus.dbus_cyc_o), 32'd0);
        if (gap) begin
            @(posedge clk); #1;
            chk({nm, ":once"}, 32'(valid_o), 32'd0);
        end
    endtask

    initial begin
        int n, r, kind;
        bit trp, rd, wr;
        logic [1:0] sz;
        logic [31:0] addr;

        rst_n = 1'b0;
        valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0; mem_size_i = 2'b00; mem_unsigned_i = 1'b0;
        alu_out_i = 32'd0; rs2_data_i = 32'd0; rd_i = 5'd0; reg_we_i = 1'b0; PC_i = 32'd0;
        is_trap_i = 1'b0; trap_code_i = 4'd0;
        dbus.dbus_dat_i = 32'd0; dbus.dbus_ack_i = 1'b0; dbus.dbus_err_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst:valid", 32'(valid_o), 32'd0);
        chk("rst:cyc", 32'(dbus.dbus_cyc_o), 32'd0);
        chk("rst:stb", 32'(dbus.dbus_stb_o), 32'd0);
        chk("rst:adr", dbus.dbus_adr_o, 32'd0);
        chk("rst:sel", 32'(dbus.dbus_sel_o), 32'd0);
        chk("rst:result", result_o, 32'd0);
        chk("rst:pc", PC_o, 32'd0);
        chk("rst:trap", 32'(is_trap_o), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add",  0, 0, 0, 2'b10, 0, 32'h0000_1234, 32'h0,         5'd5, 1, 0, 0, 32'h0,         1);
        run_op("lb",   0, 1, 0, 2'b00, 0, 32'h0000_0103, 32'h0,         5'd7, 1, 2, 0, 32'h8012_3456, 1);
        run_op("lbu",  0, 1, 0, 2'b00, 1, 32'h0000_0103, 32'h0,         5'd7, 1, 2, 0, 32'h8012_3456, 1);
        run_op("sh",   0, 0, 1, 2'b01, 0, 32'h0000_0202, 32'hAAAA_BEEF, 5'd3, 1, 0, 0, 32'h0,         1);
        run_op("lwmis",0, 1, 0, 2'b10, 0, 32'h0000_0301, 32'h0,         5'd9, 1, 0, 0, 32'h0,         1);
        run_op("swmis",0, 0, 1, 2'b10, 0, 32'h0000_0302, 32'h0,         5'd9, 1, 0, 0, 32'h0,         1);
        run_op("swerr",0, 0, 1, 2'b10, 0, 32'h0000_0300, 32'h1234_5678, 5'd1, 1, 1, 2, 32'h0,         1);
        run_op("lwto", 0, 1, 0, 2'b10, 0, 32'h0000_0400, 32'h0,         5'd2, 1, 0, 3, 32'h0,         1);
        run_op("utrap",1, 1, 0, 2'b10, 0, 32'h0000_0500, 32'h0,         5'd4, 1, 0, 0, 32'h0,         1);
        run_op("lh11", 0, 1, 0, 2'b11, 0, 32'h0000_0600, 32'h0,         5'd6, 1, 0, 0, 32'hCAFE_F00D, 0);
        run_op("lhb2b",0, 1, 0, 2'b01, 0, 32'h0000_0602, 32'h0,         5'd6, 1, 1, 0, 32'hCAFE_F00D, 1);

        // Reset in the middle of a bus access
        valid_i = 1'b1; is_trap_i = 1'b0; mem_rd_i = 1'b1; mem_wr_i = 1'b0; mem_size_i = 2'b10;
        alu_out_i = 32'h0000_0700; rd_i = 5'd8; reg_we_i = 1'b1;
        @(posedge clk); #1;
        chk("rstmid:cyc_before", 32'(dbus.dbus_cyc_o), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid:cyc", 32'(dbus.dbus_cyc_o), 32'd0);
        chk("rstmid:stb", 32'(dbus.dbus_stb_o), 32'd0);
        chk("rstmid:valid", 32'(valid_o), 32'd0);
        valid_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmid:no_retire", 32'(valid_o), 32'd0);
        run_op("lwnew",0, 1, 0, 2'b10, 0, 32'h0000_0704, 32'h0,         5'd8, 1, 1, 0, 32'h1357_9BDF, 1);

        for (int i = 0; i < 60; i++) begin
            trp  = ($urandom_range(0, 9) == 0);
            kind = $urandom_range(0, 2);
            rd   = (kind == 1);
            wr   = (kind == 2);
            sz   = 2'($urandom);
            n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr - (addr % n);
            r    = $urandom_range(0, 7);
            run_op("rnd", trp, rd, wr, sz, 1'($urandom), addr, $urandom, 5'($urandom), 1'($urandom),
                   $urandom_range(0, 3), (r < 5) ? 0 : r - 4, $urandom, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
